// File: rtl/pdm_pkg.sv
// ---------------------------------------------------------------------------
// pdm_pkg
// Shared types and default constants for the PDM microphone capture path.
//   capture_state_t  : sequencer states (IDLE, WARMUP, CAPTURE, REARM, FINISH)
//   PDM_WORD_LENGTH  : deserializer word width
//   PDM_DEPTH_LOG2   : default log2 of sample RAM depth in words
//   PDM_WARMUP_WORDS : default number of words discarded after each start
// ---------------------------------------------------------------------------
package pdm_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WARMUP  = 3'd1,
        CAPTURE = 3'd2,
        REARM   = 3'd3,
        FINISH  = 3'd4
    } capture_state_t;

    localparam int PDM_WORD_LENGTH  = 16;
    localparam int PDM_DEPTH_LOG2   = 14;
    localparam int PDM_WARMUP_WORDS = 8;

endpackage

// File: rtl/pdm_capture_ctrl_if.sv
// ---------------------------------------------------------------------------
// pdm_capture_ctrl_if
// Bundles the deserializer handshake and the sample RAM write port.
//   deser_enable : sequencer -> deserializer, low clears its shift count
//   deser_done   : deserializer -> sequencer, word-ready level
//   deser_data   : deserializer -> sequencer, completed word
//   mem_we       : sequencer -> RAM, one-cycle write strobe
//   mem_addr     : sequencer -> RAM, write address
//   mem_data     : sequencer -> RAM, write data
// Modports: master = sequencer side, slave = deserializer/RAM side.
// ---------------------------------------------------------------------------
interface pdm_capture_ctrl_if #(
    parameter int WORD_LENGTH = 16,
    parameter int DEPTH_LOG2  = 14
);
    logic                   deser_enable;
    logic                   deser_done;
    logic [WORD_LENGTH-1:0] deser_data;
    logic                   mem_we;
    logic [DEPTH_LOG2-1:0]  mem_addr;
    logic [WORD_LENGTH-1:0] mem_data;

    modport master (
        output deser_enable,
        input  deser_done,
        input  deser_data,
        output mem_we,
        output mem_addr,
        output mem_data
    );

    modport slave (
        input  deser_enable,
        output deser_done,
        output deser_data,
        input  mem_we,
        input  mem_addr,
        input  mem_data
    );
endinterface

// File: rtl/pdm_edge_detect.sv
// ---------------------------------------------------------------------------
// pdm_edge_detect
// Registered rising-edge detector; the history register resets to 0, so a
// level that is already high when reset releases counts as one edge.
//   clock_i  : system clock
//   reset_ni : asynchronous active-low reset
//   level_i  : level to watch (already synchronous to clock_i)
//   rise_o   : high in the cycle where level_i is high and was low before
// ---------------------------------------------------------------------------
module pdm_edge_detect (
    input  logic clock_i,
    input  logic reset_ni,
    input  logic level_i,
    output logic rise_o
);
    logic prev_q;

    // Remember the previous level.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= level_i;
        end
    end

    assign rise_o = level_i & ~prev_q;
endmodule

// File: rtl/pdm_capture_ctrl.sv
// ---------------------------------------------------------------------------
// pdm_capture_ctrl
// Sequencer for the PDM deserializer: enables it, drops warm-up words,
// pulses enable low for one cycle after each word and writes accepted words
// to the sample RAM at an auto-incrementing address.
//   clock_i   : system clock
//   reset_ni  : asynchronous active-low reset
//   start_i   : level, begins a capture from IDLE (ignored if stop_i is high)
//   stop_i    : level, ends a capture early
//   busy_o    : high in every state except IDLE
//   done_o    : one-cycle pulse when a capture ends
//   words_o   : words written in the current/last capture, saturating
//   overrun_o : sticky, RAM content overwritten (loop mode only)
//   bus       : deserializer handshake and RAM write port (master side)
// Build option CAPTURE_LOOP_EN: circular buffer that runs until stop_i;
// when undefined the capture ends by itself once the RAM is full.
// ---------------------------------------------------------------------------
module pdm_capture_ctrl
    import pdm_pkg::*;
#(
    parameter int WORD_LENGTH  = PDM_WORD_LENGTH,
    parameter int DEPTH_LOG2   = PDM_DEPTH_LOG2,
    parameter int WARMUP_WORDS = PDM_WARMUP_WORDS
) (
    input  logic                  clock_i,
    input  logic                  reset_ni,
    input  logic                  start_i,
    input  logic                  stop_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [DEPTH_LOG2:0]   words_o,
    output logic                  overrun_o,
    pdm_capture_ctrl_if.master    bus
);
    localparam logic [DEPTH_LOG2:0]   WORDS_FULL    = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   WORDS_ONE     = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2:0]   WORDS_LAST    = WORDS_FULL - WORDS_ONE;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE       = DEPTH_LOG2'(1);
    localparam logic [7:0]            WARMUP_TARGET = 8'(WARMUP_WORDS);

    capture_state_t         state_q,   state_d;
    logic [DEPTH_LOG2-1:0]  ptr_q,     ptr_d;
    logic [DEPTH_LOG2:0]    words_q,   words_d;
    logic [7:0]             warm_q,    warm_d;
    logic                   overrun_q, overrun_d;
    logic                   busy_q,    busy_d;
    logic                   done_q,    done_d;
    logic                   enable_q,  enable_d;
    logic                   we_q,      we_d;
    logic [DEPTH_LOG2-1:0]  addr_q,    addr_d;
    logic [WORD_LENGTH-1:0] data_q,    data_d;
    logic                   word_event_s;

    pdm_edge_detect u_word_edge (
        .clock_i  (clock_i),
        .reset_ni (reset_ni),
        .level_i  (bus.deser_done),
        .rise_o   (word_event_s)
    );

    // Next-state, counters and next values of the registered outputs.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        words_d   = words_q;
        warm_d    = warm_q;
        overrun_d = overrun_q;
        we_d      = 1'b0;
        addr_d    = addr_q;
        data_d    = data_q;

        case (state_q)
            IDLE: begin
                if (start_i && !stop_i) begin
                    ptr_d     = '0;
                    words_d   = '0;
                    warm_d    = 8'd0;
                    overrun_d = 1'b0;
                    state_d   = (WARMUP_TARGET == 8'd0) ? CAPTURE : WARMUP;
                end else begin
                    state_d = IDLE;
                end
            end
            WARMUP: begin
                // Stop wins over a simultaneous warm-up word: nothing is written here.
                if (stop_i) begin
                    state_d = FINISH;
                end else if (word_event_s) begin
                    warm_d  = warm_q + 8'd1;
                    state_d = REARM;
                end else begin
                    state_d = WARMUP;
                end
            end
            CAPTURE: begin
                if (word_event_s) begin
                    // A word arriving together with stop is still stored.
                    we_d    = 1'b1;
                    addr_d  = ptr_q;
                    data_d  = bus.deser_data;
                    ptr_d   = ptr_q + PTR_ONE;
                    words_d = (words_q == WORDS_FULL) ? words_q : words_q + WORDS_ONE;
`ifdef CAPTURE_LOOP_EN
                    if (words_q == WORDS_FULL) begin
                        overrun_d = 1'b1;
                    end else begin
                        overrun_d = overrun_q;
                    end
                    state_d = stop_i ? FINISH : REARM;
`else
                    state_d = (stop_i || (words_q == WORDS_LAST)) ? FINISH : REARM;
`endif
                end else if (stop_i) begin
                    state_d = FINISH;
                end else begin
                    state_d = CAPTURE;
                end
            end
            REARM: begin
                if (stop_i) begin
                    state_d = FINISH;
                end else if (warm_q >= WARMUP_TARGET) begin
                    state_d = CAPTURE;
                end else begin
                    state_d = WARMUP;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they appear with the state.
        busy_d   = (state_d != IDLE);
        done_d   = (state_d == FINISH);
        enable_d = (state_d == WARMUP) || (state_d == CAPTURE);
    end

    // State, counter and output registers.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            words_q   <= '0;
            warm_q    <= 8'd0;
            overrun_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            enable_q  <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            words_q   <= words_d;
            warm_q    <= warm_d;
            overrun_q <= overrun_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            enable_q  <= enable_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
        end
    end

    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign words_o          = words_q;
    assign overrun_o        = overrun_q;
    assign bus.deser_enable = enable_q;
    assign bus.mem_we       = we_q;
    assign bus.mem_addr     = addr_q;
    assign bus.mem_data     = data_q;
endmodule

// File: tb/tb_pdm_capture_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pdm_capture_ctrl
// Bench for pdm_capture_ctrl with DEPTH_LOG2=3 and WARMUP_WORDS=2. A
// deserializer model emits a word 40 cycles after enable rises; the
// reference model decides from the word index alone which words land in RAM
// and at which address, and queues them for the write monitor.
// Honours CAPTURE_LOOP_EN to select one-shot or circular-buffer scenarios.
// ---------------------------------------------------------------------------
module tb_pdm_capture_ctrl;
    import pdm_pkg::*;

    localparam int WL    = 16;
    localparam int DL    = 3;
    localparam int WW    = 2;
    localparam int DEPTH = 8;
`ifdef CAPTURE_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    logic          clock     = 1'b0;
    logic          reset_n   = 1'b0;
    logic          start     = 1'b0;
    logic          stop_main = 1'b0;
    logic          stop_req  = 1'b0;
    logic          stop_s;
    logic          busy, done, overrun;
    logic [DL:0]   words;

    assign stop_s = stop_main | stop_req;

    pdm_capture_ctrl_if #(.WORD_LENGTH(WL), .DEPTH_LOG2(DL)) bus ();

    pdm_capture_ctrl #(
        .WORD_LENGTH  (WL),
        .DEPTH_LOG2   (DL),
        .WARMUP_WORDS (WW)
    ) dut (
        .clock_i   (clock),
        .reset_ni  (reset_n),
        .start_i   (start),
        .stop_i    (stop_s),
        .busy_o    (busy),
        .done_o    (done),
        .words_o   (words),
        .overrun_o (overrun),
        .bus       (bus)
    );

    always #5 clock = ~clock;

    int tests_run    = 0;
    int tests_failed = 0;
    int done_cnt     = 0;
    int writes_seen  = 0;

    // Reference model state
    int          k         = 0;
    int          cnt       = 0;
    int          idx       = 0;
    int          max_words = 0;
    int          stop_word = -1;
    bit          use_seq   = 1'b0;
    logic        prev_busy = 1'b0;
    int          exp_words = 0;
    bit          exp_overrun = 1'b0;
    logic [15:0] w;
    logic [18:0] exp_q[$];
    logic [18:0] head;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Deserializer model plus reference model of what must be written.
    initial begin
        bus.deser_done = 1'b0;
        bus.deser_data = '0;
        forever begin
            @(negedge clock);
            stop_req = 1'b0;
            if (busy && !prev_busy) begin
                k = 0;
                exp_words = 0;
                exp_overrun = 1'b0;
            end
            prev_busy = busy;
            if (!bus.deser_enable) begin
                cnt = 0;
                bus.deser_done = 1'b0;
            end else begin
                cnt++;
                if (cnt == 40 && k < max_words) begin
                    w = use_seq ? (16'h1000 + 16'(k)) : 16'($urandom);
                    bus.deser_data = w;
                    bus.deser_done = 1'b1;
                    if (k >= WW) begin
                        idx = k - WW;
                        if (LOOP || idx < DEPTH) begin
                            exp_q.push_back({3'(idx % DEPTH), w});
                            exp_words = (idx + 1 >= DEPTH) ? DEPTH : idx + 1;
                            if (idx >= DEPTH) exp_overrun = 1'b1;
                        end
                    end
                    if (k == stop_word) stop_req = 1'b1;
                    k++;
                end
            end
        end
    end

    // Write monitor: pops the expected write whenever the RAM strobe fires.
    initial begin
        forever begin
            @(negedge clock);
            if (done) done_cnt++;
            if (bus.mem_we) begin
                writes_seen++;
                check("write_rearm_enable_low", 32'(bus.deser_enable), 32'd0);
                check("write_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    head = exp_q.pop_front();
                    check("write_addr", 32'(bus.mem_addr), 32'(head[18:16]));
                    check("write_data", 32'(bus.mem_data), 32'(head[15:0]));
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},    32'(busy),           32'd0);
        check({tag, "_done"},    32'(done),           32'd0);
        check({tag, "_words"},   32'(words),          32'd0);
        check({tag, "_overrun"}, 32'(overrun),        32'd0);
        check({tag, "_enable"},  32'(bus.deser_enable), 32'd0);
        check({tag, "_we"},      32'(bus.mem_we),     32'd0);
        check({tag, "_addr"},    32'(bus.mem_addr),   32'd0);
        check({tag, "_data"},    32'(bus.mem_data),   32'd0);
    endtask

    task automatic start_capture(input int nw, input int sw, input bit seq);
        max_words = nw;
        stop_word = sw;
        use_seq   = seq;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        check("start_busy",   32'(busy),             32'd1);
        check("start_enable", 32'(bus.deser_enable), 32'd1);
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clock);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
        check("done_within_budget", 32'(ok), 32'd1);
    endtask

    int base_w;
    int base_d;
    bit ok;

    initial begin
        // Reset values
        cyc(2);
        check_all_zero("reset");
        reset_n = 1'b1;
        cyc(2);

`ifndef CAPTURE_LOOP_EN
        // One-shot: 10 words, 2 discarded, RAM fills and the capture ends itself
        base_w = writes_seen; base_d = done_cnt;
        start_capture(10, -1, 1'b1);
        wait_done(ok);
        check("oneshot_words",   32'(words),   32'(exp_words));
        check("oneshot_overrun", 32'(overrun), 32'(exp_overrun));
        cyc(1);
        check("oneshot_busy_drop", 32'(busy), 32'd0);
        check("oneshot_done_once", 32'(done_cnt - base_d), 32'd1);
        check("oneshot_writes",    32'(writes_seen - base_w), 32'd8);
        check("oneshot_pending",   32'(exp_q.size()), 32'd0);
`else
        // Loop: 12 capture words wrap the RAM, stop arrives with the last word
        base_w = writes_seen; base_d = done_cnt;
        start_capture(14, 13, 1'b1);
        wait_done(ok);
        check("loop_done_with_write", 32'(bus.mem_we), 32'd1);
        check("loop_words",   32'(words),   32'(exp_words));
        check("loop_overrun", 32'(overrun), 32'd1);
        cyc(1);
        check("loop_done_once", 32'(done_cnt - base_d), 32'd1);
        check("loop_writes",    32'(writes_seen - base_w), 32'd12);
        check("loop_pending",   32'(exp_q.size()), 32'd0);
`endif
        cyc(3);

        // Stop during warm-up after one word
        base_w = writes_seen; base_d = done_cnt;
        start_capture(5, -1, 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clock);
            if (k >= 1) begin
                ok = 1'b1;
                break;
            end
        end
        check("warm_first_word_seen", 32'(ok), 32'd1);
        cyc(5);
        stop_main = 1'b1;
        @(negedge clock);
        stop_main = 1'b0;
        check("warm_stop_done",    32'(done), 32'd1);
        check("warm_stop_busy_n1", 32'(busy), 32'd1);
        @(negedge clock);
        check("warm_stop_done_low", 32'(done), 32'd0);
        check("warm_stop_busy_n2",  32'(busy), 32'd0);
        check("warm_stop_words",    32'(words), 32'd0);
        check("warm_stop_writes",   32'(writes_seen - base_w), 32'd0);
        check("warm_stop_done_once", 32'(done_cnt - base_d), 32'd1);
        cyc(3);

        // Stop together with the third capture word
        base_w = writes_seen;
        start_capture(10, WW + 2, 1'b0);
        wait_done(ok);
        check("stopword_we_with_done", 32'(bus.mem_we),   32'd1);
        check("stopword_addr",         32'(bus.mem_addr), 32'd2);
        check("stopword_words",        32'(words),        32'd3);
        cyc(1);
        check("stopword_writes",  32'(writes_seen - base_w), 32'd3);
        check("stopword_pending", 32'(exp_q.size()), 32'd0);
        cyc(3);

        // Reset pulse mid-capture, then a fresh capture from address 0
        base_w = writes_seen;
        start_capture(10, -1, 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clock);
            if (writes_seen - base_w >= 2) begin
                ok = 1'b1;
                break;
            end
        end
        check("midreset_capture_running", 32'(ok), 32'd1);
        cyc(5);
        reset_n = 1'b0;
        #1;
        check_all_zero("midreset");
        @(negedge clock);
        reset_n = 1'b1;
        cyc(2);
        check("midreset_pending", 32'(exp_q.size()), 32'd0);
        base_w = writes_seen;
        start_capture(10, WW + 2, 1'b1);
        wait_done(ok);
        check("restart_words", 32'(words), 32'd3);
        cyc(1);
        check("restart_writes",  32'(writes_seen - base_w), 32'd3);
        check("restart_pending", 32'(exp_q.size()), 32'd0);
        cyc(3);

        // start_i and stop_i together in IDLE
        start = 1'b1;
        stop_main = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("startstop_busy",   32'(busy),             32'd0);
            check("startstop_enable", 32'(bus.deser_enable), 32'd0);
        end
        start = 1'b0;
        stop_main = 1'b0;
        cyc(2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/pdm_capture_ctrl.md
# pdm_capture_ctrl

Sequencer for the PDM microphone deserializer. It gates the deserializer on and off, discards warm-up words while the decimator settles, and re-arms the deserializer after each word. Accepted 16-bit words go to a single-port sample RAM with an auto-incrementing address. It sits between the top-level record/stop controls and the deserializer/RAM pair, and reports word count and completion.

## Interface
Parameters:
- WORD_LENGTH, 16, width of a sample word; must match the deserializer output
- DEPTH_LOG2, 14, log2 of sample RAM depth in words
- WARMUP_WORDS, 8, words discarded after each start; range 0..255

Ports:
- clock_i  in  1  100 MHz system clock; one clock domain
- reset_ni  in  1  asynchronous, active-low reset
- start_i  in  1  level, sampled each cycle; begins a capture when idle
- stop_i  in  1  level, sampled each cycle; ends a capture early
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  one-cycle pulse when a capture ends
- words_o  out  DEPTH_LOG2+1  words written in the current/last capture; holds after done
- overrun_o  out  1  sticky; RAM content overwritten (loop mode only); cleared by start
- deser_enable_o  out  1  enable to deserializer; low resets its shift count
- deser_done_i  in  1  deserializer word-ready level
- deser_data_i  in  WORD_LENGTH  deserializer word
- mem_we_o  out  1  one-cycle RAM write strobe
- mem_addr_o  out  DEPTH_LOG2  RAM write address
- mem_data_o  out  WORD_LENGTH  RAM write data

## Operation
- Word event: rising edge of deser_done_i, detected with one register (prev low, now high).
- States:
  - IDLE: deser_enable_o=0.
    - start_i=1 and stop_i=0 -> WARMUP. On this transition: addr=0, words=0, overrun=0, warm-up counter=0.
    - start_i and stop_i both high: stay in IDLE.
  - WARMUP: deser_enable_o=1.
    - Each word event increments the warm-up counter, then -> REARM. No write.
    - When the counter reaches WARMUP_WORDS, REARM exits to CAPTURE instead of WARMUP.
    - WARMUP_WORDS=0: IDLE goes directly to CAPTURE.
  - CAPTURE: deser_enable_o=1.
    - Word event -> write word, words+1, address+1, then -> REARM.
  - REARM: deser_enable_o=0 for exactly one cycle, then return to WARMUP or CAPTURE.
  - FINISH: one cycle; done_o=1; -> IDLE.
- Stop:
  - stop_i in WARMUP, CAPTURE or REARM -> FINISH.
  - A word event in the same cycle as stop_i is still written (CAPTURE only), then -> FINISH.
- Full, without loop mode: the write that makes words = 2^DEPTH_LOG2 -> FINISH instead of REARM.
- Arithmetic: address wraps modulo 2^DEPTH_LOG2. words saturates at 2^DEPTH_LOG2 and never wraps.

## Timing
- Reset values: busy_o=0, done_o=0, words_o=0, overrun_o=0, deser_enable_o=0, mem_we_o=0, mem_addr_o=0, mem_data_o=0. State is IDLE; edge register is 0.
- start_i high in cycle N -> busy_o and deser_enable_o high in N+1.
- Word event detected in cycle N:
  - mem_we_o=1 in N+1, with mem_addr_o/mem_data_o registered from N.
  - words_o updates in N+1.
  - deser_enable_o is low in N+1 (REARM).
- stop_i in cycle N -> done_o in N+1; busy_o low in N+2.
- Reset asserted mid-capture: all outputs return to reset values immediately. The RAM is not cleared.
- start_i held high: a new capture begins the cycle after FINISH returns to IDLE.

## Configuration
- CAPTURE_LOOP_EN defined:
  - Circular buffer. Capture does not stop when full.
  - The first write after words saturates sets overrun_o.
  - The capture ends only on stop_i.
- CAPTURE_LOOP_EN undefined:
  - One-shot. Capture ends automatically when full.
  - overrun_o is tied to 0.

## Structure
- Shared package pdm_pkg holds:
  - state enum capture_state_t (IDLE, WARMUP, CAPTURE, REARM, FINISH)
  - PDM_WORD_LENGTH = 16
  - default DEPTH_LOG2 and WARMUP_WORDS constants
- One sub-module, pdm_edge_detect: registered rising-edge detector, reset to 0, reusable for the button inputs.
- Deserializer and RAM are instantiated by the parent, not inside this block.

## Test plan
Bench setup: DEPTH_LOG2=3, WARMUP_WORDS=2. The deserializer model produces a word 40 cycles after enable rises.
- Start, then 10 words 0x1000..0x1009 -> 0x1000/0x1001 discarded; 0x1002..0x1009 written to addr 0..7; done_o pulses once; words_o=8; busy_o drops (loop mode undefined).
- Loop mode, 12 capture words -> addr sequence 0..7,0..3; overrun_o=1 at the 9th write; words_o=8; no done until stop_i.
- stop_i during WARMUP after 1 word -> no mem_we_o; done_o pulse; words_o=0.
- stop_i in the same cycle as the 3rd capture word event -> word written at addr 2; words_o=3; done_o the next cycle.
- reset_ni low for 1 cycle mid-CAPTURE -> all outputs 0 immediately; start afterwards restarts at addr 0 with warm-up.
- start_i and stop_i high together in IDLE -> stays idle; busy_o=0; deser_enable_o=0.
